// File: rtl/pb_display_pkg.sv
// Shared definitions for the PicoBlaze seven-segment scan peripheral:
// register offsets inside the 8-address window, scan FSM state encodings
// and the values every register takes while reset is asserted.
package pb_display_pkg;

    // Register offsets relative to BASE_ADDRESS
    localparam logic [2:0] OFF_DIGIT0  = 3'd0;
    localparam logic [2:0] OFF_DIGIT1  = 3'd1;
    localparam logic [2:0] OFF_DIGIT2  = 3'd2;
    localparam logic [2:0] OFF_DIGIT3  = 3'd3;
    localparam logic [2:0] OFF_CONTROL = 3'd4;
    localparam logic [2:0] OFF_PERIOD  = 3'd5;
    localparam logic [2:0] OFF_BLANK   = 3'd6;
    localparam logic [2:0] OFF_STATUS  = 3'd7;

    // Scan FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_e;

    // Reset values
    localparam logic [4:0] RST_DIGIT   = 5'h00;  // {dp, hex}
    localparam logic [4:0] RST_CONTROL = 5'h00;  // {enable, mask}
    localparam logic [7:0] RST_PERIOD  = 8'h3F;
    localparam logic [7:0] RST_BLANK   = 8'h10;

endpackage

// File: rtl/pb_display_hex7seg.sv
// Combinational hex-to-seven-segment font, active-low outputs.
// Ports:
//   hex_in  [3:0] : hex value 0-F
//   dp            : decimal point request (active-high)
//   cathode [7:0] : [7] = ~dp, [6:0] = segments g..a, 0 = lit
module pb_display_hex7seg
    import pb_display_pkg::*;
(
    input  logic [3:0] hex_in,
    input  logic       dp,
    output logic [7:0] cathode
);

    logic [6:0] seg_s;

    // Font lookup: bit 0 = segment a ... bit 6 = segment g
    always_comb begin
        seg_s = 7'h7F;
        case (hex_in)
            4'h0:    seg_s = 7'h40;
            4'h1:    seg_s = 7'h79;
            4'h2:    seg_s = 7'h24;
            4'h3:    seg_s = 7'h30;
            4'h4:    seg_s = 7'h19;
            4'h5:    seg_s = 7'h12;
            4'h6:    seg_s = 7'h02;
            4'h7:    seg_s = 7'h78;
            4'h8:    seg_s = 7'h00;
            4'h9:    seg_s = 7'h10;
            4'hA:    seg_s = 7'h08;
            4'hB:    seg_s = 7'h03;
            4'hC:    seg_s = 7'h46;
            4'hD:    seg_s = 7'h21;
            4'hE:    seg_s = 7'h06;
            4'hF:    seg_s = 7'h0E;
            default: seg_s = 7'h7F;
        endcase
        cathode = {~dp, seg_s};
    end

endmodule

// File: rtl/pb_display_scan.sv
// PicoBlaze-attached 4-digit multiplexed seven-segment display scanner.
// Eight registers at BASE_ADDRESS..+7 (DIGIT0-3, CONTROL, PERIOD, BLANK,
// STATUS). Each digit slot lasts PERIOD+1 scan ticks, optionally followed by
// BLANK clocks of dark time; masked digits still consume their slot.
// Ports:
//   clk, reset (sync, active-low)
//   port_id, data_in, write_strobe, read_strobe : PicoBlaze I/O bus
//   data_out [7:0] : registered read data, one cycle after port_id
//   anode    [3:0] : digit selects, active-low
//   cathode  [7:0] : segments, active-low, [7] = dp
module pb_display_scan
    import pb_display_pkg::*;
#(
    parameter logic [7:0] BASE_ADDRESS = 8'h00,
    parameter int         TICK_DIV     = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] data_in,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] data_out,
    output logic [3:0] anode,
    output logic [7:0] cathode
);

    localparam int         PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [3:0][4:0] digit_q, digit_d;
    logic [4:0]      ctrl_q, ctrl_d;
    logic [7:0]      period_q, period_d;
    logic [7:0]      blank_q, blank_d;
    logic            fd_q, fd_d;
    scan_state_e     state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      ticks_q, ticks_d;
    logic [7:0]      dwell_q, dwell_d;
    logic [7:0]      bcnt_q, bcnt_d;
    logic [7:0]      data_out_q, data_out_d;
    logic [3:0]      anode_q, anode_d;
    logic [7:0]      cathode_q, cathode_d;

    logic [7:0]      offset_s;
    logic            hit_s;
    logic            enable_s;
    logic            tick_s;
    logic            next_slot_s;
    logic            wrap_s;
    logic            clr_s;
    logic [7:0]      font_s;

    // Window decode; subtraction wraps so the window may sit anywhere
    assign offset_s = port_id - BASE_ADDRESS;
    assign hit_s    = (offset_s[7:3] == 5'd0);
    assign enable_s = ctrl_q[4];
    assign tick_s   = (presc_q == PRESC_LAST);
    assign clr_s    = read_strobe && hit_s && (offset_s[2:0] == OFF_STATUS);

    pb_display_hex7seg u_font (
        .hex_in  (digit_q[idx_q][3:0]),
        .dp      (digit_q[idx_q][4]),
        .cathode (font_s)
    );

    // Register writes and read-data mux
    always_comb begin
        digit_d    = digit_q;
        ctrl_d     = ctrl_q;
        period_d   = period_q;
        blank_d    = blank_q;
        data_out_d = 8'h00;
        if (write_strobe && hit_s) begin
            case (offset_s[2:0])
                OFF_DIGIT0, OFF_DIGIT1, OFF_DIGIT2, OFF_DIGIT3:
                    digit_d[offset_s[1:0]] = {data_in[7], data_in[3:0]};
                OFF_CONTROL: ctrl_d   = data_in[4:0];
                OFF_PERIOD:  period_d = data_in;
                OFF_BLANK:   blank_d  = data_in;
                default:     ctrl_d   = ctrl_q;  // STATUS is read-only
            endcase
        end else begin
            ctrl_d = ctrl_q;
        end
        if (hit_s) begin
            case (offset_s[2:0])
                OFF_DIGIT0, OFF_DIGIT1, OFF_DIGIT2, OFF_DIGIT3:
                    data_out_d = {digit_q[offset_s[1:0]][4], 3'b000,
                                  digit_q[offset_s[1:0]][3:0]};
                OFF_CONTROL: data_out_d = {3'b000, ctrl_q};
                OFF_PERIOD:  data_out_d = period_q;
                OFF_BLANK:   data_out_d = blank_q;
                OFF_STATUS:  data_out_d = {4'b0000, fd_q, (state_q == ST_BLANK), idx_q};
                default:     data_out_d = 8'h00;
            endcase
        end else begin
            data_out_d = 8'h00;
        end
    end

    // Scan FSM next state, prescaler, slot/blank counters and frame flag
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        presc_d     = presc_q;
        ticks_d     = ticks_q;
        dwell_d     = dwell_q;
        bcnt_d      = bcnt_q;
        next_slot_s = 1'b0;
        wrap_s      = 1'b0;
        if (!enable_s) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
            presc_d = '0;
            ticks_d = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_DRIVE;
                    idx_d   = 2'd0;
                    presc_d = '0;
                    ticks_d = 8'd0;
                    dwell_d = period_q;
                end
                ST_DRIVE: begin
                    presc_d = tick_s ? '0 : presc_q + PW'(1);
                    if (tick_s && (ticks_q == dwell_q)) begin
                        if (blank_q != 8'd0) begin
                            state_d = ST_BLANK;
                            bcnt_d  = blank_q;  // blank length sampled here only
                        end else begin
                            next_slot_s = 1'b1;
                        end
                    end else if (tick_s) begin
                        ticks_d = ticks_q + 8'd1;
                    end else begin
                        ticks_d = ticks_q;
                    end
                end
                ST_BLANK: begin
                    if (bcnt_q <= 8'd1) begin
                        next_slot_s = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q - 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // Start of the next digit slot: realign the prescaler so every
            // slot is exactly (PERIOD+1)*TICK_DIV clocks long
            if (next_slot_s) begin
                state_d = ST_DRIVE;
                idx_d   = idx_q + 2'd1;
                wrap_s  = (idx_q == 2'd3);
                presc_d = '0;
                ticks_d = 8'd0;
                dwell_d = period_q;
            end else begin
                wrap_s = 1'b0;
            end
        end
        // Set beats a simultaneous read-clear
        if (wrap_s) begin
            fd_d = 1'b1;
        end else if (clr_s) begin
            fd_d = 1'b0;
        end else begin
            fd_d = fd_q;
        end
    end

    // Output drive computed from current state; registered below
    always_comb begin
        anode_d   = 4'hF;
        cathode_d = 8'hFF;
        if (state_q == ST_DRIVE) begin
            anode_d   = ctrl_q[idx_q] ? ~(4'b0001 << idx_q) : 4'hF;
            cathode_d = font_s;
        end else begin
            anode_d   = 4'hF;
            cathode_d = 8'hFF;
        end
    end

    // State and register flops with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            digit_q    <= {4{RST_DIGIT}};
            ctrl_q     <= RST_CONTROL;
            period_q   <= RST_PERIOD;
            blank_q    <= RST_BLANK;
            fd_q       <= 1'b0;
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            presc_q    <= '0;
            ticks_q    <= 8'd0;
            dwell_q    <= RST_PERIOD;
            bcnt_q     <= 8'd0;
            data_out_q <= 8'h00;
            anode_q    <= 4'hF;
            cathode_q  <= 8'hFF;
        end else begin
            digit_q    <= digit_d;
            ctrl_q     <= ctrl_d;
            period_q   <= period_d;
            blank_q    <= blank_d;
            fd_q       <= fd_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            presc_q    <= presc_d;
            ticks_q    <= ticks_d;
            dwell_q    <= dwell_d;
            bcnt_q     <= bcnt_d;
            data_out_q <= data_out_d;
            anode_q    <= anode_d;
            cathode_q  <= cathode_d;
        end
    end

    assign data_out = data_out_q;
    assign anode    = anode_q;
    assign cathode  = cathode_q;

endmodule

// File: tb/tb_pb_display_scan.sv
// Directed self-checking bench for pb_display_scan (BASE 0x40, TICK_DIV 4).
module tb_pb_display_scan;

    localparam logic [7:0] BASE = 8'h40;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] port_id;
    logic [7:0] data_in;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] data_out;
    logic [3:0] anode;
    logic [7:0] cathode;

    int         errors = 0;
    int         checks = 0;
    int         kc = 0;
    bit         scan_on = 1'b0;
    logic [3:0] mask_m = 4'h0;
    logic [7:0] dig_m [4];
    logic [7:0]  rd_q [$];
    logic [11:0] scan_q [$];

    pb_display_scan #(.BASE_ADDRESS(BASE), .TICK_DIV(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .port_id      (port_id),
        .data_in      (data_in),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .data_out     (data_out),
        .anode        (anode),
        .cathode      (cathode)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] font7(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Expected {anode, cathode} seen after the k-th edge following the
    // enabling write (PERIOD=0, BLANK=2, TICK_DIV=4: 4 lit + 2 dark clocks)
    function automatic logic [11:0] exp_out(input int k);
        int j, d, pos;
        logic [3:0] one_hot;
        if (k < 2) return {4'hF, 8'hFF};
        j = (k - 2) % 24;
        d = j / 6;
        pos = j % 6;
        if (pos >= 4) return {4'hF, 8'hFF};
        one_hot = 4'b0001 << d;
        return {(mask_m[d] ? ~one_hot : 4'hF), ~dig_m[d][7], font7(dig_m[d][3:0])};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (k=%0d): observed=%h expected=%h", tag, kc, obs, exp);
        end
    endtask

    task automatic step();
        logic [11:0] e;
        if (scan_on) scan_q.push_back(exp_out(kc + 1));
        @(posedge clk);
        #1;
        kc++;
        if (scan_on) begin
            e = scan_q.pop_front();
            chk("scan_anode", {4'h0, anode}, {4'h0, e[11:8]});
            chk("scan_cathode", cathode, e[7:0]);
        end
    endtask

    task automatic step_to(input int target);
        while (kc < target) step();
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] v);
        port_id = BASE + {5'd0, off};
        data_in = v;
        write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
        port_id = 8'h00;
    endtask

    task automatic rd(input logic [7:0] addr, input string tag, input logic [7:0] exp);
        port_id = addr;
        read_strobe = 1'b1;
        rd_q.push_back(exp);
        step();
        read_strobe = 1'b0;
        port_id = 8'h00;
        chk(tag, data_out, rd_q.pop_front());
    endtask

    initial begin
        reset = 1'b0; port_id = 8'h00; data_in = 8'h00;
        write_strobe = 1'b0; read_strobe = 1'b0;
        for (int i = 0; i < 4; i++) dig_m[i] = 8'h00;

        // Reset state
        repeat (2) step();
        port_id = BASE + 8'd5;
        step();
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_anode", {4'h0, anode}, 8'h0F);
        chk("rst_cathode", cathode, 8'hFF);
        reset = 1'b1; port_id = 8'h00;
        rd(BASE + 8'd4, "rst_control", 8'h00);
        rd(BASE + 8'd7, "rst_status", 8'h00);
        chk("idle_anode", {4'h0, anode}, 8'h0F);
        chk("idle_cathode", cathode, 8'hFF);
        rd(BASE + 8'd5, "rst_period", 8'h3F);
        rd(BASE + 8'd6, "rst_blank", 8'h10);
        rd(BASE + 8'd0, "rst_digit0", 8'h00);

        // Configuration, readback, unused bits, read-only STATUS, window
        wr(3'd5, 8'h00); wr(3'd6, 8'h02);
        wr(3'd0, 8'h88); wr(3'd1, 8'h01); wr(3'd2, 8'hFA); wr(3'd3, 8'h0F);
        dig_m[0] = 8'h88; dig_m[1] = 8'h01; dig_m[2] = 8'h8A; dig_m[3] = 8'h0F;
        rd(BASE + 8'd2, "digit2_unused", 8'h8A);
        rd(BASE + 8'd6, "blank_rb", 8'h02);
        wr(3'd7, 8'hFF);
        rd(BASE + 8'd7, "status_ro", 8'h00);
        rd(BASE + 8'd8, "above_window", 8'h00);
        rd(BASE - 8'd1, "below_window", 8'h00);

        // Full mask scan; frame_done set/clear/coincident set-wins
        mask_m = 4'hF; scan_on = 1'b1; kc = -1;
        wr(3'd4, 8'h1F);
        step_to(26);
        rd(BASE + 8'd7, "fd_set", 8'h08);
        rd(BASE + 8'd7, "fd_cleared", 8'h00);
        rd(BASE + 8'd4, "control_rb", 8'h1F);
        step_to(48);
        rd(BASE + 8'd7, "status_blank_d3", 8'h07);
        rd(BASE + 8'd7, "fd_set_wins", 8'h08);

        // Disable mid-DRIVE
        step_to(51);
        scan_on = 1'b0;
        wr(3'd4, 8'h00);
        step(); step();
        chk("disable_anode", {4'h0, anode}, 8'h0F);
        chk("disable_cathode", cathode, 8'hFF);
        rd(BASE + 8'd7, "disable_status", 8'h00);

        // Re-enable with mask 0x5: restart at digit 0, equal slots
        mask_m = 4'h5; scan_on = 1'b1; kc = -1;
        wr(3'd4, 8'h15);
        step_to(26);
        wr(3'd5, 8'h07);
        scan_on = 1'b0;
        step_to(29);
        chk("period_cur_slot_lit", {4'h0, anode}, 8'h0E);
        step();
        chk("period_cur_slot_end", {4'h0, anode}, 8'h0F);
        step_to(65);
        chk("period_long_slot_dark", {4'h0, anode}, 8'h0F);
        step();
        chk("period_next_digit", {4'h0, anode}, 8'h0B);
        chk("digit2_cathode", cathode, 8'h08);
        step_to(69);
        wr(3'd2, 8'h03);
        step();
        chk("digit_write_live", cathode, 8'hB0);
        chk("digit_write_anode", {4'h0, anode}, 8'h0B);
        step_to(97);
        chk("period_slot_last", {4'h0, anode}, 8'h0B);

        // Reset mid-BLANK
        reset = 1'b0; port_id = BASE + 8'd5;
        step();
        chk("rst_blank_anode", {4'h0, anode}, 8'h0F);
        chk("rst_blank_cathode", cathode, 8'hFF);
        chk("rst_blank_data_out", data_out, 8'h00);
        step();
        reset = 1'b1; port_id = 8'h00;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_anode", {4'h0, anode}, 8'h0F);
        end
        for (int i = 0; i < 4; i++) rd(BASE + 8'(i), "post_rst_digit", 8'h00);
        rd(BASE + 8'd4, "post_rst_control", 8'h00);
        rd(BASE + 8'd5, "post_rst_period", 8'h3F);
        rd(BASE + 8'd6, "post_rst_blank", 8'h10);
        rd(BASE + 8'd7, "post_rst_status", 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
